// File: rtl/titan_ex_pkg.sv
// titan_ex_pkg: shared opcodes, md FSM states and EX/MEM control bundle for the Titan execute stage
package titan_ex_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_e;
  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] waddr;
  } ex_mem_ctl_t;
  function automatic logic md_is_mul(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M mul/div unit (shift-add multiply, restoring divide); MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module muldiv_iter
  import titan_ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            hold,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_e         state;
  md_op_e            op_e, op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] prod, prod_s, next_prod;
  logic [XLEN-1:0]   ub, abs_a, abs_b, quo, rem;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              na, nb, neg_p, neg_r, b_zero;
  assign op_e  = md_op_e'(op);
  assign na    = (op_e inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a[XLEN-1];
  assign nb    = (op_e inside {MD_MULH, MD_DIV, MD_REM}) & b[XLEN-1];
  assign abs_a = na ? -a : a;
  assign abs_b = nb ? -b : b;
  // prod holds {accumulator, multiplier} for mul and {remainder, quotient} for div
  assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, prod[0] ? ub : {XLEN{1'b0}}};
  assign div_sh    = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
  assign div_diff  = div_sh - {1'b0, ub};
  assign next_prod = md_is_mul(op_q) ? {mul_sum, prod[XLEN-1:1]}
                   : div_diff[XLEN] ? {div_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                   : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
  // divisor zero leaves remainder = |A|, so only the quotient needs an override
  assign prod_s = neg_p ? -prod : prod;
  assign quo    = b_zero ? {XLEN{1'b1}} : neg_p ? -prod[XLEN-1:0] : prod[XLEN-1:0];
  assign rem    = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
  assign result = op_q == MD_MUL ? prod_s[XLEN-1:0]
                : md_is_mul(op_q) ? prod_s[2*XLEN-1:XLEN]
                : op_q[1] ? rem : quo;
  assign busy = !abort & ((state == MD_IDLE & start) | state == MD_CALC);
  assign done = state == MD_DONE;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
  assign fast_p = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      prod   <= '0;
      ub     <= '0;
      op_q   <= MD_MUL;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
    end else if (abort) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          op_q   <= op_e;
          ub     <= abs_b;
          neg_p  <= na ^ nb;
          neg_r  <= na;
          b_zero <= b == '0;
          cnt    <= CNT_W'(XLEN - 1);
`ifdef MULDIV_FAST_MUL_EN
          prod   <= md_is_mul(op_e) ? fast_p : {{XLEN{1'b0}}, abs_a};
          state  <= md_is_mul(op_e) ? MD_DONE : MD_CALC;
`else
          prod   <= {{XLEN{1'b0}}, abs_a};
          state  <= MD_CALC;
`endif
        end
        MD_CALC: begin
          prod  <= next_prod;
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? MD_DONE : MD_CALC;
        end
        MD_DONE: if (!hold) state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: Titan execute stage with single-cycle ALU, iterative mul/div and the EX/MEM register
module ex_muldiv_stage
  import titan_ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_stall_i,
  input  logic            ex_flush_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_port_a_i,
  input  logic [XLEN-1:0] ex_port_b_i,
  input  logic [3:0]      ex_alu_op_i,
  input  logic            ex_md_en_i,
  input  logic [2:0]      ex_md_op_i,
  input  logic [4:0]      ex_waddr_i,
  input  logic            ex_we_i,
  output logic [XLEN-1:0] ex_fwd_dat_o,
  output logic            ex_busy_o,
  output logic            mem_valid_o,
  output logic [XLEN-1:0] mem_result_o,
  output logic [4:0]      mem_waddr_o,
  output logic            mem_we_o
);
  typedef struct packed {
    ex_mem_ctl_t     ctl;
    logic [XLEN-1:0] result;
  } ex_mem_t;
  ex_mem_t          mem_q;
  alu_op_e          alu_op;
  logic [XLEN-1:0]  alu_res, md_res, a, b;
  logic [CNT_W-1:0] shamt;
  logic             md_done;
  assign a      = ex_port_a_i;
  assign b      = ex_port_b_i;
  assign shamt  = b[CNT_W-1:0];
  assign alu_op = alu_op_e'(ex_alu_op_i);
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = a + b;
      ALU_SUB:    alu_res = a - b;
      ALU_SLL:    alu_res = a << shamt;
      ALU_SLT:    alu_res = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:   alu_res = XLEN'(a < b);
      ALU_XOR:    alu_res = a ^ b;
      ALU_SRL:    alu_res = a >> shamt;
      ALU_SRA:    alu_res = $signed(a) >>> shamt;
      ALU_OR:     alu_res = a | b;
      ALU_AND:    alu_res = a & b;
      ALU_PASS_B: alu_res = b;
      default:    alu_res = '0;
    endcase
  end
  muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_md (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (ex_valid_i & ex_md_en_i & !ex_flush_i),
    .abort  (ex_flush_i),
    .hold   (ex_stall_i),
    .op     (ex_md_op_i),
    .a      (a),
    .b      (b),
    .busy   (ex_busy_o),
    .done   (md_done),
    .result (md_res)
  );
  assign ex_fwd_dat_o = md_done ? md_res : alu_res;
  always_ff @(posedge clk_i) begin
    if (rst_i | ex_flush_i) mem_q <= '0;
    else if (ex_stall_i) mem_q <= mem_q;
    else if (ex_busy_o) mem_q <= '0;
    else mem_q <= '{ctl: '{valid: ex_valid_i, we: ex_we_i & ex_valid_i, waddr: ex_waddr_i},
                    result: ex_fwd_dat_o};
  end
  assign mem_valid_o  = mem_q.ctl.valid;
  assign mem_we_o     = mem_q.ctl.we;
  assign mem_waddr_o  = mem_q.ctl.waddr;
  assign mem_result_o = mem_q.result;
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// tb_ex_muldiv_stage: directed self-checking bench for ex_muldiv_stage (honours MULDIV_FAST_MUL_EN)
module tb_ex_muldiv_stage;
  import titan_ex_pkg::*;
  logic        clk = 1'b0;
  logic        rst, stall, flush, valid, md_en, we;
  logic [31:0] a, b;
  logic [3:0]  alu_op;
  logic [2:0]  md_op;
  logic [4:0]  waddr;
  logic [31:0] fwd, mem_result;
  logic        busy, mem_valid, mem_we;
  logic [4:0]  mem_waddr;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_stage #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ex_stall_i   (stall),
    .ex_flush_i   (flush),
    .ex_valid_i   (valid),
    .ex_port_a_i  (a),
    .ex_port_b_i  (b),
    .ex_alu_op_i  (alu_op),
    .ex_md_en_i   (md_en),
    .ex_md_op_i   (md_op),
    .ex_waddr_i   (waddr),
    .ex_we_i      (we),
    .ex_fwd_dat_o (fwd),
    .ex_busy_o    (busy),
    .mem_valid_o  (mem_valid),
    .mem_result_o (mem_result),
    .mem_waddr_o  (mem_waddr),
    .mem_we_o     (mem_we)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic drive_idle();
    valid = 1'b0; md_en = 1'b0; we = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle(); a = '0; b = '0; alu_op = '0; md_op = '0; waddr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({mem_valid, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_valid_we got=%b required=00", {mem_valid, mem_we}); end
    checks++; if (mem_waddr !== 5'd0 || mem_result !== 32'd0) begin failures++; $display("FAIL reset_fields waddr=%0d result=%h required 0", mem_waddr, mem_result); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
    rst = 1'b0;
  endtask

  task automatic run_alu(input logic [3:0] op, input logic [31:0] av, bv, exp, input string nm);
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b0; alu_op = op; a = av; b = bv; we = 1'b1; waddr = 5'd3;
    @(negedge clk);
    checks++; if (fwd !== exp) begin failures++; $display("FAIL %s fwd got=%h required=%h", nm, fwd, exp); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy got=%b required=0", nm, busy); end
    @(posedge clk); #1;
    checks++;
    if ({mem_valid, mem_we, mem_waddr} !== {2'b11, 5'd3} || mem_result !== exp) begin
      failures++; $display("FAIL %s mem got v=%b we=%b wa=%0d r=%h required v=1 we=1 wa=3 r=%h", nm, mem_valid, mem_we, mem_waddr, mem_result, exp);
    end
    drive_idle();
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] av, bv, exp, input string nm);
    int n;
    int exp_busy;
    exp_busy = 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) exp_busy = 1;
`endif
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b1; md_op = op; a = av; b = bv; we = 1'b1; waddr = 5'd9; alu_op = 4'd0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin n++; @(negedge clk); end
    checks++; if (n !== exp_busy) begin failures++; $display("FAIL %s busy_cycles got=%0d required=%0d", nm, n, exp_busy); end
    checks++; if (fwd !== exp) begin failures++; $display("FAIL %s fwd got=%h required=%h", nm, fwd, exp); end
    @(posedge clk); #1;
    checks++;
    if ({mem_valid, mem_we, mem_waddr} !== {2'b11, 5'd9} || mem_result !== exp) begin
      failures++; $display("FAIL %s mem got v=%b we=%b wa=%0d r=%h required v=1 we=1 wa=9 r=%h", nm, mem_valid, mem_we, mem_waddr, mem_result, exp);
    end
    drive_idle();
  endtask

  task automatic test_alu();
    run_alu(ALU_ADD, 32'd3, 32'd4, 32'd7, "alu_add");
    run_alu(ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, "alu_sub");
    run_alu(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, "alu_slt");
    run_alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, "alu_sltu");
    run_alu(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, "alu_sra");
    run_alu(ALU_SLL, 32'd1, 32'd31, 32'h8000_0000, "alu_sll");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b0; alu_op = ALU_XOR; a = 32'hF0F0_0000; b = 32'h0FF0_0000; we = 1'b1; waddr = 5'd4;
    @(posedge clk); #1;
    checks++; if (mem_valid !== 1'b1 || mem_result !== 32'hFF00_0000) begin failures++; $display("FAIL b2b_first got v=%b r=%h required v=1 r=ff000000", mem_valid, mem_result); end
    alu_op = ALU_OR; a = 32'h1; b = 32'h2; we = 1'b0; waddr = 5'd5;
    @(posedge clk); #1;
    checks++; if ({mem_valid, mem_we, mem_waddr} !== {2'b10, 5'd5} || mem_result !== 32'd3) begin failures++; $display("FAIL b2b_second got v=%b we=%b wa=%0d r=%h required v=1 we=0 wa=5 r=3", mem_valid, mem_we, mem_waddr, mem_result); end
    valid = 1'b0; we = 1'b1;
    @(posedge clk); #1;
    checks++; if ({mem_valid, mem_we} !== 2'b00) begin failures++; $display("FAIL b2b_we_gate got v=%b we=%b required 00", mem_valid, mem_we); end
    drive_idle();
  endtask

  task automatic test_md();
    run_md(MD_DIVU, 32'd100, 32'd7, 32'd14, "divu_100_7");
    run_md(MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
    run_md(MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
    run_md(MD_REMU, 32'd5, 32'd0, 32'd5, "remu_by0");
    run_md(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "mulh_m1");
    run_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu_m1_2");
    run_md(MD_MUL, 32'd6, 32'd7, 32'd42, "mul_6_7");
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd7; we = 1'b1; waddr = 5'd9;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_same_cycle got=%b required=0", busy); end
    @(posedge clk); #1;
    drive_idle();
    checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_after got v=%b busy=%b required 0 0", mem_valid, busy); end
    run_alu(ALU_ADD, 32'd2, 32'd2, 32'd4, "flush_next_add");
    @(posedge clk); #1;
    valid = 1'b1; alu_op = ALU_ADD; a = 32'd1; b = 32'd1; we = 1'b1; waddr = 5'd7; flush = 1'b1;
    @(posedge clk); #1;
    checks++; if ({mem_valid, mem_we} !== 2'b00 || mem_result !== 32'd0) begin failures++; $display("FAIL flush_alu got v=%b we=%b r=%h required 0 0 0", mem_valid, mem_we, mem_result); end
    drive_idle();
  endtask

  task automatic test_stall_done();
    int n;
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd7; we = 1'b1; waddr = 5'd9;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin n++; @(negedge clk); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_valid !== 1'b0 || fwd !== 32'd14 || busy !== 1'b0) begin
        failures++; $display("FAIL stall_hold_%0d got v=%b fwd=%h busy=%b required v=0 fwd=e busy=0", i, mem_valid, fwd, busy);
      end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_valid !== 1'b1 || mem_result !== 32'd14) begin failures++; $display("FAIL stall_release got v=%b r=%h required v=1 r=e", mem_valid, mem_result); end
    drive_idle();
    @(posedge clk); #1;
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL stall_no_dup got v=%b required=0", mem_valid); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    valid = 1'b1; md_en = 1'b0; alu_op = ALU_ADD; a = 32'd3; b = 32'd4; we = 1'b1; waddr = 5'd3;
    @(posedge clk); #1;
    md_en = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd7; waddr = 5'd9; stall = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (mem_valid !== 1'b1 || mem_result !== 32'd7 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre got v=%b r=%h busy=%b required v=1 r=7 busy=1", mem_valid, mem_result, busy); end
    rst = 1'b1; drive_idle();
    @(posedge clk); #1;
    checks++;
    if ({mem_valid, mem_we, mem_waddr} !== 7'd0 || mem_result !== 32'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_clear got v=%b we=%b wa=%0d r=%h busy=%b required all 0", mem_valid, mem_we, mem_waddr, mem_result, busy);
    end
    rst = 1'b0;
    run_md(MD_DIVU, 32'd1000, 32'd10, 32'd100, "rstmid_restart");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_md();
    test_flush();
    test_stall_done();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
